oled_spi_seq: RTL and testbench

//  Parametrised SPI command sequencer for the PmodOLEDrgb (SSD1331) path. Latches a frame of up to
//  MAX_BYTES bytes from the AXI register bank and shifts them MSB-first under one CS-low window.

---
 rtl/oled_spi_seq.sv | 277 +++++++++++++++++++++++++++
 tb/tb_oled_spi_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_seq.sv
// oled_spi_seq
//   SPI command sequencer for the PmodOLEDrgb (SSD1331). A start request in IDLE
//   latches a frame of up to MAX_BYTES bytes, plus one D/C bit per byte. The frame
//   is then shifted out MSB-first inside a single CS-low window. The SCLK half-period
//   (CLK_DIV cycles) and the idle level (CPOL) are configurable; the slave always
//   samples MOSI on the rising SCLK edge. Supports abort and zero-length frames.
//
// Ports
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_start      frame request, honoured only in IDLE
//   i_abort      terminates the active frame (ignored in IDLE and DONE)
//   i_num_bytes  frame length, clamped to MAX_BYTES
//   i_bytes      byte slots, slot k = [8k+7:8k], slot 0 sent first
//   i_dc_bits    bit k drives o_dc during byte k (0 = command, 1 = data)
//   o_busy       frame in progress (SETUP..HOLD)
//   o_done       one-cycle end-of-frame pulse
//   o_aborted    qualifies o_done: frame was aborted
//   o_byte_idx   index of the byte being shifted, 0 when idle
//   o_mosi       serial data
//   o_sclk       serial clock
//   o_cs         chip select, active low
//   o_dc         data/command select
module oled_spi_seq #(
  parameter int CLK_DIV   = 50,
  parameter int MAX_BYTES = 16,
  parameter bit CPOL      = 1'b1,
  localparam int CNT_W    = $clog2(MAX_BYTES + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [CNT_W-1:0]       i_num_bytes,
  input  logic [8*MAX_BYTES-1:0] i_bytes,
  input  logic [MAX_BYTES-1:0]   i_dc_bits,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_aborted,
  output logic [CNT_W-1:0]       o_byte_idx,
  output logic                   o_mosi,
  output logic                   o_sclk,
  output logic                   o_cs,
  output logic                   o_dc
);

  localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] MAX_N     = CNT_W'(MAX_BYTES);
  localparam logic [3:0]       HALF_LAST = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [3:0]             half_q, half_d;      // SCLK half-period within a byte
  logic [CNT_W-1:0]       byte_q, byte_d;
  logic [CNT_W-1:0]       n_q, n_d;
  logic [8*MAX_BYTES-1:0] bytes_q, bytes_d;
  logic [MAX_BYTES-1:0]   dc_bits_q, dc_bits_d;

  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic                   mosi_q, mosi_d;
  logic                   sclk_q, sclk_d;
  logic                   cs_q, cs_d;
  logic                   dc_q, dc_d;

  logic                   active_s;
  logic                   div_last_s;
  logic                   abort_hit_s;
  logic [CNT_W-1:0]       n_clamp_s;
  logic [7:0]             cur_byte_s;
  logic                   cur_dc_s;

  assign active_s   = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                      (state_q == ST_GAP)   || (state_q == ST_HOLD);
  assign div_last_s = (div_q == DIV_LAST);
  assign n_clamp_s  = (i_num_bytes > MAX_N) ? MAX_N : i_num_bytes;

  // Outputs are derived from the next state, so the byte and D/C selection
  // must use the next-cycle frame contents (they are latched on the same edge).
  assign cur_byte_s = 8'(bytes_d >> {byte_d, 3'b000});
  assign cur_dc_s   = 1'(dc_bits_d >> byte_d);

  // State, counter and frame registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      half_q    <= 4'd0;
      byte_q    <= '0;
      n_q       <= '0;
      bytes_q   <= '0;
      dc_bits_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      byte_q    <= byte_d;
      n_q       <= n_d;
      bytes_q   <= bytes_d;
      dc_bits_q <= dc_bits_d;
    end
  end

  // Next-state, timing counters and frame latch.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    half_d      = half_q;
    byte_d      = byte_q;
    n_d         = n_q;
    bytes_d     = bytes_q;
    dc_bits_d   = dc_bits_q;
    abort_hit_s = 1'b0;
    if (active_s && i_abort) begin
      // Abort takes priority over every phase expiry, including the end of HOLD.
      state_d     = ST_DONE;
      abort_hit_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            bytes_d   = i_bytes;
            dc_bits_d = i_dc_bits;
            n_d       = n_clamp_s;
            div_d     = '0;
            half_d    = 4'd0;
            byte_d    = '0;
            if (n_clamp_s == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SETUP;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETUP, ST_GAP: begin
          if (div_last_s) begin
            state_d = ST_SHIFT;
            div_d   = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          if (!div_last_s) begin
            div_d = div_q + DIV_W'(1);
          end else begin
            div_d = '0;
            if (half_q != HALF_LAST) begin
              half_d = half_q + 4'd1;
            end else begin
              half_d = 4'd0;
              if (byte_q == (n_q - CNT_W'(1))) begin
                state_d = ST_HOLD;
              end else begin
                state_d = ST_GAP;
                byte_d  = byte_q + CNT_W'(1);
              end
            end
          end
        end
        ST_HOLD: begin
          if (div_last_s) begin
            state_d = ST_DONE;
            div_d   = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state; the result is registered below.
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    idx_d     = '0;
    mosi_d    = mosi_q;
    sclk_d    = CPOL;
    cs_d      = 1'b1;
    dc_d      = dc_q;
    case (state_d)
      ST_IDLE: begin
        idx_d = '0;
      end
      ST_SETUP: begin
        cs_d   = 1'b0;
        busy_d = 1'b1;
        dc_d   = cur_dc_s;
        mosi_d = cur_byte_s[7];
      end
      ST_SHIFT: begin
        cs_d   = 1'b0;
        busy_d = 1'b1;
        idx_d  = byte_d;
        // Odd half-periods are SCLK high, so rising edges fall on odd halves for
        // either CPOL. MOSI moves at the start of even halves (a falling edge) and
        // carries bit 7-(half/2), i.e. the inverted half[3:1].
        sclk_d = half_d[0];
        mosi_d = cur_byte_s[~half_d[3:1]];
      end
      ST_GAP: begin
        cs_d   = 1'b0;
        busy_d = 1'b1;
        idx_d  = byte_d;
        dc_d   = cur_dc_s;
        mosi_d = cur_byte_s[7];
      end
      ST_HOLD: begin
        cs_d   = 1'b0;
        busy_d = 1'b1;
        idx_d  = byte_d;
      end
      ST_DONE: begin
        done_d    = 1'b1;
        aborted_d = abort_hit_s;
      end
      default: begin
        idx_d = '0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      idx_q     <= '0;
      mosi_q    <= 1'b0;
      sclk_q    <= CPOL;
      cs_q      <= 1'b1;
      dc_q      <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      idx_q     <= idx_d;
      mosi_q    <= mosi_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      dc_q      <= dc_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_aborted  = aborted_q;
  assign o_byte_idx = idx_q;
  assign o_mosi     = mosi_q;
  assign o_sclk     = sclk_q;
  assign o_cs       = cs_q;
  assign o_dc       = dc_q;

endmodule

// File: tb/tb_oled_spi_seq.sv
// Bench for oled_spi_seq: two instances (CPOL=0 and CPOL=1) share all inputs.
// Expected timing is computed from the frame rules: byte b, bit 7-k is sampled on
// the rising edge at cycle 1 + D + 17*D*b + (2k+1)*D, and the frame ends at cycle
// 1 + D*(17N+1), or at abort cycle + 1 when the frame is aborted.
module tb_oled_spi_seq;
  localparam int D  = 2;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [CW-1:0]     num;
  logic [8*MB-1:0]   bytes;
  logic [MB-1:0]     dcb;
  logic [1:0]        busy, done, aborted, mosi, sclk, cs, dc;
  logic [1:0][CW-1:0] idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  oled_spi_seq #(.CLK_DIV(D), .MAX_BYTES(MB), .CPOL(1'b0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_num_bytes(num), .i_bytes(bytes), .i_dc_bits(dcb),
    .o_busy(busy[0]), .o_done(done[0]), .o_aborted(aborted[0]), .o_byte_idx(idx[0]),
    .o_mosi(mosi[0]), .o_sclk(sclk[0]), .o_cs(cs[0]), .o_dc(dc[0])
  );

  oled_spi_seq #(.CLK_DIV(D), .MAX_BYTES(MB), .CPOL(1'b1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_num_bytes(num), .i_bytes(bytes), .i_dc_bits(dcb),
    .o_busy(busy[1]), .o_done(done[1]), .o_aborted(aborted[1]), .o_byte_idx(idx[1]),
    .o_mosi(mosi[1]), .o_sclk(sclk[1]), .o_cs(cs[1]), .o_dc(dc[1])
  );

  function automatic int rise_cycle(input int b, input int k);
    return 1 + D + 17 * D * b + (2 * k + 1) * D;
  endfunction

  function automatic logic [8*MB-1:0] rand_bytes();
    logic [8*MB-1:0] v;
    for (int i = 0; i < MB; i++) v[8*i +: 8] = 8'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; num = '0; bytes = '0; dcb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [CW+6:0] got, exp;
      got = {busy[d], done[d], aborted[d], idx[d], mosi[d], sclk[d], cs[d], dc[d]};
      exp = {1'b0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0, d[0], 1'b1, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset dut%0d got=%b exp=%b", d, got, exp);
      end
    end
    rst = 1'b0;
  endtask

  // Runs one frame and checks it against the model. abort_at/start_at < 0 disables.
  task automatic run_frame(input string name, input int n, input logic [8*MB-1:0] fb,
                           input logic [MB-1:0] fdc, input int abort_at,
                           input int start_at, input bit abort_with_start);
    int ne, t_end, exp_done, nrise_exp;
    bit ab;
    int rises[2], toggles[2], cs_low[2], done_cyc[2];
    logic prev_sclk[2];
    ne        = (n > MB) ? MB : n;
    t_end     = (ne == 0) ? 1 : 1 + D * (17 * ne + 1);
    ab        = (abort_at > 0) && (ne > 0) && (abort_at < t_end);
    exp_done  = ab ? abort_at + 1 : t_end;
    nrise_exp = 0;
    for (int b = 0; b < ne; b++)
      for (int k = 0; k < 8; k++)
        if (!ab || rise_cycle(b, k) <= abort_at) nrise_exp++;
    @(negedge clk);
    num = CW'(n); bytes = fb; dcb = fdc; start = 1'b1; abort = abort_with_start;
    for (int d = 0; d < 2; d++) begin
      rises[d] = 0; toggles[d] = 0; cs_low[d] = 0; done_cyc[d] = -1;
      prev_sclk[d] = sclk[d];
    end
    @(posedge clk);
    for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bytes = rand_bytes(); dcb = MB'($urandom); num = CW'($urandom);
      end
      start = (cyc == start_at);
      abort = (cyc == abort_at);
      for (int d = 0; d < 2; d++) begin
        if (sclk[d] !== prev_sclk[d]) toggles[d]++;
        if (cs[d] === 1'b0) cs_low[d]++;
        if (prev_sclk[d] === 1'b0 && sclk[d] === 1'b1) begin
          int r, b, k;
          r = rises[d]; b = r / 8; k = r % 8;
          total++;
          if (r >= 8 * ne || cyc != rise_cycle(b, k)) begin
            bad++;
            $display("FAIL %s dut%0d edge#%0d at cycle %0d, expected cycle %0d (of %0d edges)",
                     name, d, r, cyc, rise_cycle(b, k), 8 * ne);
          end else begin
            total++;
            if ({mosi[d], dc[d], idx[d]} !== {fb[8*b+7-k], fdc[b], CW'(b)}) begin
              bad++;
              $display("FAIL %s dut%0d byte%0d bit%0d mosi/dc/idx got=%b exp=%b", name, d, b,
                       7 - k, {mosi[d], dc[d], idx[d]}, {fb[8*b+7-k], fdc[b], CW'(b)});
            end
          end
          rises[d]++;
        end
        if (cyc == 1 && ne > 0) begin
          total++;
          if ({busy[d], cs[d], dc[d], mosi[d], sclk[d]} !== {1'b1, 1'b0, fdc[0], fb[7], d[0]}) begin
            bad++;
            $display("FAIL %s dut%0d setup busy/cs/dc/mosi/sclk got=%b exp=%b", name, d,
                     {busy[d], cs[d], dc[d], mosi[d], sclk[d]}, {1'b1, 1'b0, fdc[0], fb[7], d[0]});
          end
        end
        if (done[d] === 1'b1 && done_cyc[d] < 0) begin
          done_cyc[d] = cyc;
          total++;
          if (cyc != exp_done ||
              {aborted[d], cs[d], sclk[d], busy[d]} !== {ab, 1'b1, d[0], 1'b0}) begin
            bad++;
            $display("FAIL %s dut%0d done at %0d (exp %0d) aborted/cs/sclk/busy got=%b exp=%b",
                     name, d, cyc, exp_done, {aborted[d], cs[d], sclk[d], busy[d]},
                     {ab, 1'b1, d[0], 1'b0});
          end
        end
        if (cyc > exp_done) begin
          total++;
          if ({done[d], cs[d], sclk[d], busy[d], idx[d]} !== {1'b0, 1'b1, d[0], 1'b0, {CW{1'b0}}}) begin
            bad++;
            $display("FAIL %s dut%0d idle after done at cycle %0d got=%b", name, d, cyc,
                     {done[d], cs[d], sclk[d], busy[d], idx[d]});
          end
        end
        prev_sclk[d] = sclk[d];
      end
    end
    start = 1'b0; abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (done_cyc[d] != exp_done) begin
        bad++;
        $display("FAIL %s dut%0d done cycle got=%0d exp=%0d", name, d, done_cyc[d], exp_done);
      end
      total++;
      if (rises[d] != nrise_exp) begin
        bad++;
        $display("FAIL %s dut%0d rising edges got=%0d exp=%0d", name, d, rises[d], nrise_exp);
      end
      total++;
      if (cs_low[d] != exp_done - 1) begin
        bad++;
        $display("FAIL %s dut%0d cs low cycles got=%0d exp=%0d", name, d, cs_low[d], exp_done - 1);
      end
      if (!ab) begin
        total++;
        if (toggles[d] != 16 * ne) begin
          bad++;
          $display("FAIL %s dut%0d sclk toggles got=%0d exp=%0d", name, d, toggles[d], 16 * ne);
        end
      end
    end
  endtask

  task automatic test_single_byte();
    run_frame("single_a5", 1, {{(8*MB-8){1'b0}}, 8'hA5}, '0, -1, -1, 1'b0);
  endtask

  task automatic test_multi_byte();
    run_frame("three_bytes", 3, {8'h00, 8'h5F, 8'h00, 8'h15}, 4'b0100, -1, -1, 1'b0);
  endtask

  task automatic test_zero_len();
    run_frame("zero_len", 0, rand_bytes(), 4'hF, -1, -1, 1'b0);
  endtask

  task automatic test_abort();
    // byte 1, bit 3 is rising edge index k=4 of byte 1
    run_frame("abort_b1", 3, rand_bytes(), 4'b0110, rise_cycle(1, 4), -1, 1'b0);
    run_frame("after_abort", 2, rand_bytes(), 4'b0011, -1, -1, 1'b0);
    // abort on the last HOLD cycle still reports an abort
    run_frame("abort_hold", 2, rand_bytes(), 4'b0001, D * (17 * 2 + 1), -1, 1'b0);
    run_frame("start_abort_idle", 1, rand_bytes(), 4'b0001, -1, -1, 1'b1);
  endtask

  task automatic test_start_ignored();
    run_frame("start_mid", 2, rand_bytes(), 4'b0010, -1, 20, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    num = CW'(3); bytes = rand_bytes(); dcb = 4'hF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      logic [CW+6:0] got, exp;
      got = {busy[d], done[d], aborted[d], idx[d], mosi[d], sclk[d], cs[d], dc[d]};
      exp = {1'b0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0, d[0], 1'b1, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_mid dut%0d got=%b exp=%b", d, got, exp);
      end
    end
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done !== 2'b00 || cs !== 2'b11 || sclk !== 2'b10) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid activity after reset in %0d cycles, expected 0", seen);
    end
  endtask

  task automatic test_clamp();
    run_frame("clamp", MB + 3, {MB{8'h3C}}, 4'b1010, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      int n, ne, te, ab_at;
      n     = $urandom_range(0, MB + 3);
      ne    = (n > MB) ? MB : n;
      te    = 1 + D * (17 * ne + 1);
      ab_at = -1;
      if (ne > 0 && $urandom_range(0, 3) == 0) ab_at = $urandom_range(1, te - 1);
      run_frame("random", n, rand_bytes(), MB'($urandom), ab_at, -1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_zero_len();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_clamp();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
